roce_meta_arbiter: RTL

ROCE_META_ARBITER -- requirements
Module: roce_meta_arbiter

---
 rtl/roce_krnl_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 33 +++
 rtl/roce_meta_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/roce_krnl_pkg.sv
// rtl/roce_krnl_pkg.sv - shared RoCE kernel types: meta arbiter FSM states and TX meta field offsets
// Contents:
//   meta_arb_state_t  - arbiter FSM encoding (IDLE, ARB, SEND)
//   META_*_LSB/_W     - bit positions of fields inside the TX meta word
package roce_krnl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_SEND = 2'd2
    } meta_arb_state_t;

    localparam int META_OPCODE_LSB = 0;
    localparam int META_OPCODE_W   = 3;
    localparam int META_QPN_LSB    = 3;
    localparam int META_QPN_W      = 24;
    localparam int META_LADDR_LSB  = 27;
    localparam int META_LADDR_W    = 48;
    localparam int META_RADDR_LSB  = 75;
    localparam int META_RADDR_W    = 48;
    localparam int META_LEN_LSB    = 123;
    localparam int META_LEN_W      = 32;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin winner search
// Ports:
//   req   in  N   request vector
//   last  in  IW  index of the previous winner; search starts at last+1 and wraps
//   grant out N   one-hot winner (zero when no request)
//   valid out 1   a winner exists
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic          valid
);

    logic [IW-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        // Offsets 1..N visit every requester once, ending on last itself.
        for (int off = 1; off <= N; off++) begin
            idx = IW'((int'(last) + off) % N);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/roce_meta_arbiter.sv
// rtl/roce_meta_arbiter.sv - round-robin arbiter feeding requester metas to the RoCE TX meta stream
// Ports:
//   ap_clk, areset            clock, synchronous active-high reset
//   enable                    grants allowed when high
//   s_req_*                   NUM_REQ requester meta streams (tdata slice i*META_W)
//   m_axis_tx_meta_*          granted meta towards the RoCE stack
//   s_axis_tx_status_*        completion beats, each retires one outstanding meta
//   outstanding               metas handed over but not yet completed
//   grant_id                  requester of the current/last grant
//   status_underflow          sticky: completion seen with nothing outstanding
module roce_meta_arbiter
    import roce_krnl_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int META_W    = 256,
    parameter int MAX_OUTST = 16
) (
    input  logic                          ap_clk,
    input  logic                          areset,
    input  logic                          enable,
    input  logic [NUM_REQ-1:0]            s_req_tvalid,
    output logic [NUM_REQ-1:0]            s_req_tready,
    input  logic [NUM_REQ*META_W-1:0]     s_req_tdata,
    output logic                          m_axis_tx_meta_tvalid,
    input  logic                          m_axis_tx_meta_tready,
    output logic [META_W-1:0]             m_axis_tx_meta_tdata,
    output logic [META_W/8-1:0]           m_axis_tx_meta_tkeep,
    output logic                          m_axis_tx_meta_tlast,
    input  logic                          s_axis_tx_status_tvalid,
    output logic                          s_axis_tx_status_tready,
    output logic [$clog2(MAX_OUTST):0]    outstanding,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          status_underflow
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int OW = $clog2(MAX_OUTST) + 1;

    meta_arb_state_t state, state_next;

    logic [NUM_REQ-1:0] arb_grant;
    logic               arb_valid;
    logic [IW-1:0]      win_id;
    logic [META_W-1:0]  win_data;
    logic               can_grant;
    logic               do_grant;
    logic               meta_hs;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req   (s_req_tvalid),
        .last  (grant_id),
        .grant (arb_grant),
        .valid (arb_valid)
    );

    always_comb begin
        win_id   = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
                win_id   = IW'(i);
                win_data = s_req_tdata[i*META_W +: META_W];
            end
        end
    end

    assign can_grant = (outstanding < OW'(MAX_OUTST));
    assign meta_hs   = m_axis_tx_meta_tvalid && m_axis_tx_meta_tready;

    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) state_next = ST_ARB;
            end
            ST_ARB: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                end else if (arb_valid && can_grant && !areset) begin
                    do_grant   = 1'b1;
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                // A transfer in progress completes even if enable drops.
                if (meta_hs) state_next = enable ? ST_ARB : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The requester handshake is combinational so the accept and the
    // output-register load happen on the same edge.
    assign s_req_tready = do_grant ? arb_grant : '0;

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state                 <= ST_IDLE;
            m_axis_tx_meta_tvalid <= 1'b0;
            m_axis_tx_meta_tdata  <= '0;
            grant_id              <= IW'(NUM_REQ - 1);
            outstanding           <= '0;
            status_underflow      <= 1'b0;
        end else begin
            state <= state_next;
            if (do_grant) begin
                m_axis_tx_meta_tvalid <= 1'b1;
                m_axis_tx_meta_tdata  <= win_data;
                grant_id              <= win_id;
            end else if (meta_hs) begin
                m_axis_tx_meta_tvalid <= 1'b0;
            end
            case ({meta_hs, s_axis_tx_status_tvalid})
                2'b10: outstanding <= outstanding + OW'(1);
                2'b01: begin
                    if (outstanding == '0) status_underflow <= 1'b1;
                    else                   outstanding <= outstanding - OW'(1);
                end
                default: ;
            endcase
        end
    end

    assign m_axis_tx_meta_tkeep    = '1;
    assign m_axis_tx_meta_tlast    = 1'b1;
    assign s_axis_tx_status_tready = 1'b1;

endmodule
